// File: rtl/s2p_deser_pkg.sv
// s2p_deser shared types and constants.
// FSM state encoding and default word width.
package s2p_deser_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_deser_if.sv
// s2p_deser serial-in / word-out bundle.
// master: upstream + consumer side, slave: deserializer.
interface s2p_deser_if
  import s2p_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                     sin;
  logic                     sin_en;
  logic                     clr;
  logic [WIDTH-1:0]         dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic                     overrun;
  logic                     busy;
  logic [$clog2(WIDTH)-1:0] bit_cnt;

  modport master (
    output sin, sin_en, clr, dout_ready,
    input  dout, dout_valid, overrun,
    input  busy, bit_cnt
  );

  modport slave (
    input  sin, sin_en, clr, dout_ready,
    output dout, dout_valid, overrun,
    output busy, bit_cnt
  );

endinterface

// File: rtl/s2p_deser_ctrl.sv
// s2p_deser control: IDLE/COLLECT FSM and bit counter.
// done flags the edge that completes a word.
module s2p_deser_ctrl
  import s2p_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin_en,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;

  assign done = sin_en && !clr && (bit_cnt == LAST);

  // state, counter and registered busy advance on each qualified bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (sin_en) begin
      unique case (state)
        IDLE: begin
          state   <= COLLECT;
          bit_cnt <= CW'(1);
          busy    <= 1'b1;
        end
        COLLECT: begin
          if (bit_cnt == LAST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/s2p_deser.sv
// s2p_deser top: shift register and output word register.
// A completed word loads dout on its final bit edge.
module s2p_deser
  import s2p_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  s2p_deser_if.slave bus
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] nxt;
  logic             done;

  s2p_deser_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .sin_en (bus.sin_en),
    .clr    (bus.clr),
    .bit_cnt(bus.bit_cnt),
    .busy   (bus.busy),
    .done   (done)
  );

  assign nxt = MSB_FIRST ? {sreg[WIDTH-2:0], bus.sin}
                         : {bus.sin, sreg[WIDTH-1:1]};

  // partial word shift plus output handshake and overrun tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.overrun    <= 1'b0;
    end else if (bus.clr) begin
      sreg           <= '0;
      bus.dout_valid <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (bus.sin_en) begin
        sreg <= done ? '0 : nxt;
      end
      if (done) begin
        if (!bus.dout_valid || bus.dout_ready) begin
          bus.dout       <= nxt;
          bus.dout_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.dout_valid && bus.dout_ready) begin
        bus.dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2p_deser.sv
// s2p_deser bench: MSB-first and LSB-first instances share stimulus.
// Queue-based scoreboard plus per-cycle status model.
module tb_s2p_deser;
  import s2p_deser_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  s2p_deser_if #(.WIDTH(W)) bm ();
  s2p_deser_if #(.WIDTH(W)) bl ();

  s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bm.slave)
  );

  s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sbq_m[$];
  logic [W-1:0] sbq_l[$];

  int           bits[$];
  bit           m_valid = 1'b0;
  bit           m_ovr   = 1'b0;
  logic [W-1:0] m_dm    = '0;
  logic [W-1:0] m_dl    = '0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    sbq_m.delete();
    sbq_l.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dm    = '0;
    m_dl    = '0;
  endtask

  task automatic model_step(bit s, bit e, bit c, bit r);
    int  wm;
    int  wl;
    bit  fin;
    fin = 1'b0;
    if (c) begin
      bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    if (e) begin
      bits.push_back(int'(s));
      if (bits.size() == W) begin
        fin = 1'b1;
        wm  = 0;
        wl  = 0;
        for (int i = 0; i < W; i++) begin
          wm = wm * 2 + bits[i];
          wl = wl + (bits[i] << i);
        end
        bits.delete();
        if (!m_valid || r) begin
          m_dm    = W'(wm);
          m_dl    = W'(wl);
          m_valid = 1'b1;
          sbq_m.push_back(W'(wm));
          sbq_l.push_back(W'(wl));
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (!fin && m_valid && r) m_valid = 1'b0;
  endtask

  task automatic status();
    chk("m.valid", int'(bm.dout_valid), int'(m_valid));
    chk("l.valid", int'(bl.dout_valid), int'(m_valid));
    chk("m.overrun", int'(bm.overrun), int'(m_ovr));
    chk("l.overrun", int'(bl.overrun), int'(m_ovr));
    chk("m.bit_cnt", int'(bm.bit_cnt), bits.size());
    chk("l.bit_cnt", int'(bl.bit_cnt), bits.size());
    chk("m.busy", int'(bm.busy), int'(bits.size() != 0));
    chk("l.busy", int'(bl.busy), int'(bits.size() != 0));
    chk("m.dout", int'(bm.dout), int'(m_dm));
    chk("l.dout", int'(bl.dout), int'(m_dl));
  endtask

  task automatic cycle(bit s, bit e, bit c, bit r);
    bm.sin = s;  bl.sin = s;
    bm.sin_en = e;  bl.sin_en = e;
    bm.clr = c;  bl.clr = c;
    bm.dout_ready = r;  bl.dout_ready = r;
    @(posedge clk);
    model_step(s, e, c, r);
    #1;
    status();
  endtask

  task automatic send(logic [W-1:0] w, bit r);
    for (int i = W - 1; i >= 0; i--) cycle(w[i], 1'b1, 1'b0, r);
  endtask

  // scoreboard monitor: a word is newly presented when valid follows
  // an edge that had no valid word or accepted the previous one
  bit pv_m = 1'b0, pr_m = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_m = 1'b0;
      pr_m = 1'b0;
    end else begin
      if (bm.dout_valid && (!pv_m || pr_m)) begin
        if (sbq_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_m: unexpected word %0d", bm.dout);
        end else begin
          chk("sb_m.word", int'(bm.dout), int'(sbq_m.pop_front()));
        end
      end
      pv_m = bm.dout_valid;
      pr_m = bm.dout_ready;
    end
  end

  bit pv_l = 1'b0, pr_l = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_l = 1'b0;
      pr_l = 1'b0;
    end else begin
      if (bl.dout_valid && (!pv_l || pr_l)) begin
        if (sbq_l.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_l: unexpected word %0d", bl.dout);
        end else begin
          chk("sb_l.word", int'(bl.dout), int'(sbq_l.pop_front()));
        end
      end
      pv_l = bl.dout_valid;
      pr_l = bl.dout_ready;
    end
  end

  initial begin
    rst_n = 1'b0;
    bm.sin = 1'b0;  bl.sin = 1'b0;
    bm.sin_en = 1'b0;  bl.sin_en = 1'b0;
    bm.clr = 1'b0;  bl.clr = 1'b0;
    bm.dout_ready = 1'b0;  bl.dout_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    status();
    rst_n = 1'b1;

    // basic word, accepted on the following edge
    send(4'b1010, 1'b1);
    chk("w1010.dout", int'(bm.dout), 4'b1010);
    chk("w1010.lsb", int'(bl.dout), 4'b0101);
    chk("w1010.valid", int'(bm.dout_valid), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1010.clear", int'(bm.dout_valid), 0);

    // gap of two idle cycles mid-word
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap.bit_cnt", int'(bm.bit_cnt), 2);
      chk("gap.busy", int'(bm.busy), 1);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("gap.dout", int'(bm.dout), 4'b1010);
    chk("gap.lsb", int'(bl.dout), 4'b0101);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun then clr
    send(4'b1010, 1'b0);
    send(4'b0110, 1'b0);
    chk("ovr.dout", int'(bm.dout), 4'b1010);
    chk("ovr.flag", int'(bm.overrun), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr.overrun", int'(bm.overrun), 0);
    chk("clr.valid", int'(bm.dout_valid), 0);
    chk("clr.dout", int'(bm.dout), 4'b1010);

    // completion on the same edge as acceptance
    send(4'b1010, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("same.dout", int'(bm.dout), 4'b1100);
    chk("same.valid", int'(bm.dout_valid), 1);
    chk("same.overrun", int'(bm.overrun), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // clr overrides sin_en mid-word
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr.bit_cnt", int'(bm.bit_cnt), 0);
    chk("clr.busy", int'(bm.busy), 0);
    send(4'b0011, 1'b1);
    chk("clr.next", int'(bm.dout), 4'b0011);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-word
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.dout", int'(bm.dout), 0);
    chk("rst.valid", int'(bm.dout_valid), 0);
    chk("rst.bit_cnt", int'(bm.bit_cnt), 0);
    chk("rst.busy", int'(bm.busy), 0);
    chk("rst.overrun", int'(bm.overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b1110, 1'b1);
    chk("rst.next", int'(bm.dout), 4'b1110);
    chk("rst.lsb", int'(bl.dout), 4'b0111);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("sb_m.drained", sbq_m.size(), 0);
    chk("sb_l.drained", sbq_l.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
